kf76489_register_controller: RTL

//  CPU-side write sequencer for the KF76489 PSG core.
//  - Synchronises the async CPU write strobe and decodes SN76489 latch/data bytes.
//  - Drives a one-cycle register-write strobe into one of three tone generators or the noise generator.
//  - Holds READY low for a fixed busy window after every accepted write.

---
 rtl/kf76489_pkg.sv | 26 ++
 rtl/kf76489_write_synchronizer.sv | 39 +++
 rtl/kf76489_register_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/kf76489_pkg.sv
// ============================================================================
// kf76489_pkg : shared types and constants for the KF76489 register controller
// Revision    : 1.0
// ============================================================================
`default_nettype none

package kf76489_pkg;

  typedef enum logic {
    FREQ  = 1'b0,
    ATTEN = 1'b1
  } reg_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    STROBE = 2'd2,
    BUSY   = 2'd3
  } state_t;

  localparam logic [1:0] NOISE_CHANNEL = 2'd3;
  localparam int         LATCH_BIT     = 7;

endpackage

`default_nettype wire

// File: rtl/kf76489_write_synchronizer.sv
// ============================================================================
// kf76489_write_synchronizer : CPU strobe synchroniser plus rising-edge detect
// Revision                   : 1.0
// ============================================================================
`default_nettype none

module kf76489_write_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic chip_enable_n_i,
  input  logic write_enable_n_i,
  output logic wr_active_o,
  output logic wr_rise_o
);

  // Each stage holds {chip_enable_n, write_enable_n}; reset to the inactive level
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic                        wr_prev_q;
  logic                        w_wr_act;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= '1;
      wr_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], {chip_enable_n_i, write_enable_n_i}};
      wr_prev_q <= w_wr_act;
    end
  end

  assign w_wr_act    = ~sync_q[SYNC_STAGES-1][1] & ~sync_q[SYNC_STAGES-1][0];
  assign wr_active_o = w_wr_act;
  assign wr_rise_o   = w_wr_act & ~wr_prev_q;

endmodule

`default_nettype wire

// File: rtl/kf76489_register_controller.sv
// ============================================================================
// kf76489_register_controller : CPU write sequencer / SN76489 byte decoder
// Option : KF76489_DATA_BYTE_ATTEN_EN enables data-byte attenuation/noise writes
// Revision : 1.0
// ============================================================================
`default_nettype none

module kf76489_register_controller
  import kf76489_pkg::*;
#(
  parameter int READY_CYCLES = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_enable,
  input  logic       chip_enable_n,
  input  logic       write_enable_n,
  input  logic [7:0] data_bus_in,
  output logic       ready,
  output logic [7:0] internal_data_bus,
  output logic [2:0] write_frequency_h,
  output logic [2:0] write_frequency_l,
  output logic [3:0] write_attenuation,
  output logic       write_noise
);

`ifdef KF76489_DATA_BYTE_ATTEN_EN
  localparam logic DATA_BYTE_EXT = 1'b1;
`else
  localparam logic DATA_BYTE_EXT = 1'b0;
`endif
  localparam logic [7:0] BUSY_LAST = 8'(READY_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] data_q;
  logic [1:0] latch_ch_q, latch_ch_d;
  reg_type_t  latch_type_q, latch_type_d;
  logic [7:0] busy_cnt_q, busy_cnt_d;
  logic [7:0] bus_q, bus_d;
  logic [2:0] freq_h_q, freq_h_d;
  logic [2:0] freq_l_q, freq_l_d;
  logic [3:0] atten_q, atten_d;
  logic       noise_q, noise_d;
  logic       w_wr_rise;
  logic       w_is_latch;
  logic       w_apply_ext;

  kf76489_write_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock           (clock),
    .reset           (reset),
    .chip_enable_n_i (chip_enable_n),
    .write_enable_n_i(write_enable_n),
    .wr_active_o     (),
    .wr_rise_o       (w_wr_rise)
  );

  assign w_is_latch  = data_q[LATCH_BIT];
  assign w_apply_ext = w_is_latch | DATA_BYTE_EXT;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= 8'h00;
      latch_ch_q   <= 2'd0;
      latch_type_q <= FREQ;
      busy_cnt_q   <= 8'd0;
      bus_q        <= 8'h00;
      freq_h_q     <= 3'b000;
      freq_l_q     <= 3'b000;
      atten_q      <= 4'b0000;
      noise_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      latch_ch_q   <= latch_ch_d;
      latch_type_q <= latch_type_d;
      busy_cnt_q   <= busy_cnt_d;
      bus_q        <= bus_d;
      freq_h_q     <= freq_h_d;
      freq_l_q     <= freq_l_d;
      atten_q      <= atten_d;
      noise_q      <= noise_d;
      if (state_q == IDLE && w_wr_rise) begin
        data_q <= data_bus_in;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    latch_ch_d   = latch_ch_q;
    latch_type_d = latch_type_q;
    busy_cnt_d   = busy_cnt_q;
    bus_d        = bus_q;
    freq_h_d     = 3'b000;
    freq_l_d     = 3'b000;
    atten_d      = 4'b0000;
    noise_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_wr_rise) state_d = DECODE;
      end
      DECODE: begin
        state_d = STROBE;
        if (w_is_latch) begin
          latch_ch_d   = data_q[6:5];
          latch_type_d = reg_type_t'(data_q[4]);
        end
        // Strobes are registered here so they appear one cycle later, in STROBE
        if (latch_type_d == ATTEN) begin
          if (w_apply_ext) begin
            bus_d   = {data_q[3:0], 4'h0};
            atten_d = 4'b0001 << latch_ch_d;
          end
        end else if (latch_ch_d == NOISE_CHANNEL) begin
          if (w_apply_ext) begin
            bus_d   = {1'b0, data_q[2:0], 4'h0};
            noise_d = 1'b1;
          end
        end else if (w_is_latch) begin
          bus_d    = {data_q[3:0], 4'h0};
          freq_h_d = 3'b001 << latch_ch_d;
        end else begin
          bus_d    = {data_q[5:0], 2'b00};
          freq_l_d = 3'b001 << latch_ch_d;
        end
      end
      STROBE: begin
        state_d    = BUSY;
        busy_cnt_d = 8'd0;
      end
      BUSY: begin
        if (clock_enable) begin
          if (busy_cnt_q == BUSY_LAST) begin
            busy_cnt_d = 8'd0;
            state_d    = IDLE;
          end else begin
            busy_cnt_d = busy_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready             = (state_q == IDLE);
  assign internal_data_bus = bus_q;
  assign write_frequency_h = freq_h_q;
  assign write_frequency_l = freq_l_q;
  assign write_attenuation = atten_q;
  assign write_noise       = noise_q;

endmodule

`default_nettype wire
